// File: rtl/pill_feeder.sv
// pill_feeder: simulated hopper/feeder that produces the pill-detect pulse
// stream for the bottling controller's pill counter.
//
// One pulse per dispensed pill until the bottle reaches the BCD target, then
// a bottle-change gap. Tracks hopper inventory with refill and saturation.
//
// Ports:
//   clk_1khz            system clock
//   switch_clr          synchronous active-high reset
//   enable              controller RUNNING level
//   tgt_p3/p2/p1        BCD pills-per-bottle (hundreds/tens/units)
//   emergncy_stop       latches ESTOP until switch_clr
//   simu_hopper_stop    freezes the pill-period counter
//   simu_hopper_add     refill request, rising-edge detected
//   simu_conveyor_stop  freezes the bottle-change gap
//   pill_pulse          pill-detect pulse, PULSE_W cycles wide
//   hopper_level        pill inventory (binary)
//   hopper_empty        hopper_level == 0
//   conveyor_busy       bottle change in progress
//   fault               emergency stop latched
//   config_err          enabled with a 000 target
//
// Build option: define PILL_FEEDER_JITTER_EN to add 0..7 cycles of LFSR
// jitter to each pill interval, latched on FEED entry.
//
// state  | meaning
// IDLE   | waiting for enable with a non-zero target
// FEED   | pill-period counter running toward the next pulse
// PULSE  | pill_pulse high for PULSE_W cycles
// CHANGE | bottle-change gap, conveyor_busy high
// STALL  | hopper empty or stopped, waiting to resume
// ESTOP  | emergency latched, cleared only by switch_clr
module pill_feeder #(
   parameter int PILL_PERIOD = 200,
   parameter int PULSE_W     = 2,
   parameter int BOTTLE_GAP  = 500,
   parameter int HOPPER_INIT = 50,
   parameter int HOPPER_ADD  = 10,
   parameter int HOPPER_MAX  = 99
) (
   input  logic       clk_1khz,
   input  logic       switch_clr,
   input  logic       enable,
   input  logic [3:0] tgt_p1,
   input  logic [3:0] tgt_p2,
   input  logic [3:0] tgt_p3,
   input  logic       emergncy_stop,
   input  logic       simu_hopper_stop,
   input  logic       simu_hopper_add,
   input  logic       simu_conveyor_stop,
   output logic       pill_pulse,
   output logic [6:0] hopper_level,
   output logic       hopper_empty,
   output logic       conveyor_busy,
   output logic       fault,
   output logic       config_err
);

   localparam int CW = $clog2(PILL_PERIOD + 8);
   localparam int GW = $clog2(BOTTLE_GAP + 1);
   localparam int PW = $clog2(PULSE_W + 1);
   localparam logic [CW-1:0] TERM_BASE = CW'(PILL_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FEED, S_PULSE, S_CHANGE, S_STALL, S_ESTOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] per_cnt_q, per_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [PW-1:0] pw_cnt_q, pw_cnt_d;
   logic [11:0]   pill_cnt_q, pill_cnt_d;
   logic [6:0]    level_q, level_d;
   logic          add_q, add_d;
   logic          config_err_q, config_err_d;

   logic [CW-1:0] term_cnt;
   logic [11:0]   target;
   logic          dispense;
   logic          refill;
   logic [7:0]    lvl_base, lvl_sum;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd9) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4]  = 4'd0;
            r[11:8] = (v[11:8] != 4'd9) ? v[11:8] + 4'd1 : 4'd0;
         end
      end
      return r;
   endfunction

   assign target = {tgt_p3, tgt_p2, tgt_p1};

`ifdef PILL_FEEDER_JITTER_EN
   logic [7:0] lfsr_q, lfsr_d;
   logic [2:0] jit_q, jit_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      jit_d  = jit_q;
      if (state_d == S_FEED && state_q != S_FEED) jit_d = lfsr_q[2:0];
      term_cnt = TERM_BASE + CW'(jit_q);
   end

   always_ff @(posedge clk_1khz) begin
      if (switch_clr) begin
         lfsr_q <= 8'hA5;
         jit_q  <= 3'd0;
      end else begin
         lfsr_q <= lfsr_d;
         jit_q  <= jit_d;
      end
   end
`else
   always_comb term_cnt = TERM_BASE;
`endif

   always_ff @(posedge clk_1khz) begin
      if (switch_clr) begin
         state_q      <= S_IDLE;
         per_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         pw_cnt_q     <= '0;
         pill_cnt_q   <= '0;
         level_q      <= 7'(HOPPER_INIT);
         add_q        <= 1'b0;
         config_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         per_cnt_q    <= per_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         pw_cnt_q     <= pw_cnt_d;
         pill_cnt_q   <= pill_cnt_d;
         level_q      <= level_d;
         add_q        <= add_d;
         config_err_q <= config_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      per_cnt_d    = per_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      pw_cnt_d     = pw_cnt_q;
      pill_cnt_d   = pill_cnt_q;
      config_err_d = 1'b0;
      dispense     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               if (target == 12'h000) begin
                  config_err_d = 1'b1;
               end else begin
                  state_d    = S_FEED;
                  per_cnt_d  = '0;
                  pill_cnt_d = '0;
               end
            end
         end
         S_FEED: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (!simu_hopper_stop) begin
               // The terminal-count decision is also frozen by hopper_stop,
               // so a hold of N cycles delays the pulse by exactly N.
               if (per_cnt_q == term_cnt) begin
                  if (level_q != 7'd0) begin
                     state_d    = S_PULSE;
                     pw_cnt_d   = '0;
                     dispense   = 1'b1;
                     pill_cnt_d = bcd_inc(pill_cnt_q);
                  end else begin
                     state_d = S_STALL;
                  end
               end else begin
                  per_cnt_d = per_cnt_q + CW'(1);
               end
            end
         end
         S_PULSE: begin
            if (pw_cnt_q == PW'(PULSE_W - 1)) begin
               if (!enable) begin
                  state_d = S_IDLE;
               end else if (pill_cnt_q == target) begin
                  state_d   = S_CHANGE;
                  gap_cnt_d = GW'(BOTTLE_GAP - 1);
               end else begin
                  state_d   = S_FEED;
                  per_cnt_d = '0;
               end
            end else begin
               pw_cnt_d = pw_cnt_q + PW'(1);
            end
         end
         S_CHANGE: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (!simu_conveyor_stop) begin
               if (gap_cnt_q == '0) begin
                  state_d    = S_FEED;
                  per_cnt_d  = '0;
                  pill_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q - GW'(1);
               end
            end
         end
         S_STALL: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (level_q != 7'd0 && !simu_hopper_stop) begin
               state_d   = S_FEED;
               per_cnt_d = '0;
            end
         end
         S_ESTOP: state_d = S_ESTOP;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE) pill_cnt_d = '0;
      if (emergncy_stop) begin
         state_d      = S_ESTOP;
         dispense     = 1'b0;
         config_err_d = 1'b0;
      end
   end

   // Refill and dispense may land on the same edge; saturate the combined sum.
   always_comb begin
      add_d    = simu_hopper_add;
      refill   = simu_hopper_add & ~add_q & (state_q != S_ESTOP);
      lvl_base = {1'b0, level_q} - {7'd0, dispense};
      lvl_sum  = lvl_base + 8'(HOPPER_ADD);
      level_d  = lvl_base[6:0];
      if (refill) level_d = (lvl_sum > 8'(HOPPER_MAX)) ? 7'(HOPPER_MAX) : lvl_sum[6:0];
   end

   always_comb begin
      pill_pulse    = (state_q == S_PULSE);
      conveyor_busy = (state_q == S_CHANGE);
      fault         = (state_q == S_ESTOP);
      config_err    = config_err_q;
      hopper_level  = level_q;
      hopper_empty  = (level_q == 7'd0);
   end

endmodule

// File: tb/tb_pill_feeder.sv
module tb_pill_feeder;

   localparam int PP = 200, PW = 2, GAP = 500, INIT = 50, ADD = 10, MAXL = 99;

   logic       clk = 1'b0;
   logic       switch_clr = 1'b1, enable = 1'b0;
   logic [3:0] tgt_p1 = 4'd3, tgt_p2 = 4'd0, tgt_p3 = 4'd0;
   logic       emergncy_stop = 1'b0, simu_hopper_stop = 1'b0;
   logic       simu_hopper_add = 1'b0, simu_conveyor_stop = 1'b0;
   logic       pill_pulse, hopper_empty, conveyor_busy, fault, config_err;
   logic [6:0] hopper_level;

   pill_feeder dut (
      .clk_1khz(clk), .switch_clr(switch_clr), .enable(enable),
      .tgt_p1(tgt_p1), .tgt_p2(tgt_p2), .tgt_p3(tgt_p3),
      .emergncy_stop(emergncy_stop), .simu_hopper_stop(simu_hopper_stop),
      .simu_hopper_add(simu_hopper_add), .simu_conveyor_stop(simu_conveyor_stop),
      .pill_pulse(pill_pulse), .hopper_level(hopper_level),
      .hopper_empty(hopper_empty), .conveyor_busy(conveyor_busy),
      .fault(fault), .config_err(config_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int errors = 0, checks = 0, nprint = 0;
   int npulse = 0;
   bit pp_prev = 1'b0;
   bit chk_on = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (pill_pulse && !pp_prev) npulse++;
      pp_prev = pill_pulse;
   end

   // Behavioural model: decimal bottle count, cycles-remaining timers.
   localparam int M_IDLE = 0, M_FEED = 1, M_PULSE = 2, M_GAP = 3, M_STALL = 4, M_STOP = 5;
   int m_mode = M_IDLE, m_left = 0, m_level = INIT, m_bottle = 0;
   bit m_add_prev = 1'b0, m_cerr = 1'b0;

   always @(posedge clk) begin : model
      int tgt, nmode, dec;
      bit rise, ncerr;
      tgt = int'(tgt_p3) * 100 + int'(tgt_p2) * 10 + int'(tgt_p1);
      if (switch_clr) begin
         m_mode = M_IDLE; m_left = 0; m_level = INIT; m_bottle = 0;
         m_add_prev = 1'b0; m_cerr = 1'b0;
      end else begin
         rise = simu_hopper_add && !m_add_prev;
         nmode = m_mode; dec = 0; ncerr = 1'b0;
         if (emergncy_stop) nmode = M_STOP;
         else case (m_mode)
            M_IDLE: if (enable) begin
               if (tgt == 0) ncerr = 1'b1;
               else begin nmode = M_FEED; m_left = PP; m_bottle = 0; end
            end
            M_FEED: if (!enable) nmode = M_IDLE;
               else if (!simu_hopper_stop) begin
                  m_left--;
                  if (m_left == 0) begin
                     if (m_level > 0) begin
                        nmode = M_PULSE; m_left = PW; dec = 1;
                        m_bottle = (m_bottle + 1) % 1000;
                     end else nmode = M_STALL;
                  end
               end
            M_PULSE: begin
               m_left--;
               if (m_left == 0) begin
                  if (!enable) nmode = M_IDLE;
                  else if (m_bottle == tgt) begin nmode = M_GAP; m_left = GAP; end
                  else begin nmode = M_FEED; m_left = PP; end
               end
            end
            M_GAP: if (!enable) nmode = M_IDLE;
               else if (!simu_conveyor_stop) begin
                  m_left--;
                  if (m_left == 0) begin nmode = M_FEED; m_left = PP; m_bottle = 0; end
               end
            M_STALL: if (!enable) nmode = M_IDLE;
               else if (m_level > 0 && !simu_hopper_stop) begin nmode = M_FEED; m_left = PP; end
            default: ;
         endcase
         if (nmode == M_IDLE) m_bottle = 0;
         if (m_mode != M_STOP && rise) begin
            m_level = m_level - dec + ADD;
            if (m_level > MAXL) m_level = MAXL;
         end else m_level = m_level - dec;
         m_add_prev = simu_hopper_add;
         m_mode = nmode;
         m_cerr = ncerr;
      end
   end

   always @(negedge clk) begin
      logic [11:0] act, exp;
      if (chk_on) begin
         act = {pill_pulse, hopper_level, hopper_empty, conveyor_busy, fault, config_err};
         exp = {m_mode == M_PULSE, 7'(m_level), m_level == 0, m_mode == M_GAP,
                m_mode == M_STOP, m_cerr};
         checks++;
         if (act !== exp) begin
            errors++;
            if (nprint < 20) begin
               nprint++;
               $display("FAIL scoreboard cyc=%0d got=%h expected=%h", cyc, act, exp);
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit cond(int w);
      case (w)
         0: return pill_pulse;
         1: return conveyor_busy;
         2: return !conveyor_busy;
         3: return hopper_empty;
         default: return hopper_level == 7'd2;
      endcase
   endfunction

   task automatic wait_for(int w, int budget, output int t);
      bit found;
      found = 1'b0;
      t = -1;
      for (int i = 0; i < budget && !found; i++) begin
         if (cond(w)) begin found = 1'b1; t = cyc; end
         else tick(1);
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL wait_%0d: timeout after %0d cycles", w, budget);
      end
   endtask

   task automatic add_edge();
      simu_hopper_add = 1'b1; tick(1);
      simu_hopper_add = 1'b0; tick(1);
   endtask

   initial begin
      int t0, t, tb, te, tf, n0;
      tick(1);
      chk_on = 1'b1;
      tick(2);
      chk("rst_pulse", pill_pulse, 0);
      chk("rst_level", hopper_level, 50);
      chk("rst_fault", fault, 0);
      chk("rst_busy", conveyor_busy, 0);
      chk("rst_cerr", config_err, 0);
      switch_clr = 1'b0; tick(2);

      // Nominal bottle of 3.
      enable = 1'b1; tick(1); t0 = cyc;
      wait_for(0, 1000, t); chk("pulse1_at", t - t0, 200);
      tick(1); chk("pulse1_hi2", pill_pulse, 1);
      tick(1); chk("pulse1_lo", pill_pulse, 0);
      wait_for(0, 1000, t); chk("pulse2_at", t - t0, 402); tick(2);
      wait_for(0, 1000, t); chk("pulse3_at", t - t0, 604);
      wait_for(1, 1000, tb); chk("gap_start", tb - t, 2);
      wait_for(2, 1000, te); chk("gap_len", te - tb, 500);
      chk("level_47", hopper_level, 47);
      wait_for(0, 1000, t); chk("bottle2_first", t - te, 200);

      // Freeze inputs.
      tick(2); tf = cyc;
      tick(30); simu_hopper_stop = 1'b1; tick(100); simu_hopper_stop = 1'b0;
      wait_for(0, 1000, t); chk("hstop_delay", t - tf, 300);
      tick(2); wait_for(0, 1000, t);
      wait_for(1, 1000, tb);
      tick(100); simu_conveyor_stop = 1'b1; tick(50); simu_conveyor_stop = 1'b0;
      wait_for(2, 1000, te); chk("cstop_gap", te - tb, 550);
      chk("level_44", hopper_level, 44);

      // Emergency on first pulse-high cycle.
      wait_for(0, 1000, t);
      emergncy_stop = 1'b1; tick(1);
      chk("estop_pulse", pill_pulse, 0);
      chk("estop_fault", fault, 1);
      chk("estop_level", hopper_level, 43);
      emergncy_stop = 1'b0; tick(5);
      enable = 1'b0; tick(3); enable = 1'b1; tick(3);
      chk("fault_latched", fault, 1);
      add_edge(); chk("estop_no_refill", hopper_level, 43);
      switch_clr = 1'b1; enable = 1'b0; tick(1); switch_clr = 1'b0;
      chk("clr_level", hopper_level, 50);
      chk("clr_fault", fault, 0);

      // Target 000.
      tgt_p1 = 4'd0; n0 = npulse;
      enable = 1'b1; tick(3);
      chk("cerr_set", config_err, 1);
      tick(300); chk("cerr_no_pulse", npulse - n0, 0);
      enable = 1'b0; tick(2); chk("cerr_clear", config_err, 0);

      // Saturation.
      tgt_p2 = 4'd9; tgt_p1 = 4'd9; enable = 1'b1;
      for (int i = 0; i < 5; i++) begin wait_for(0, 1000, t); tick(2); end
      chk("level_45", hopper_level, 45);
      for (int i = 0; i < 5; i++) add_edge();
      chk("level_95", hopper_level, 95);
      add_edge(); chk("sat_add", hopper_level, 99);
      for (int i = 0; i < 4; i++) begin wait_for(0, 1000, t); tick(2); end
      chk("level_95b", hopper_level, 95);
      tf = cyc; tick(199);
      simu_hopper_add = 1'b1; tick(1);
      chk("disp_add_pulse", pill_pulse, 1);
      chk("disp_add_level", hopper_level, 99);
      simu_hopper_add = 1'b0; tick(2);

      // Drain to 2, drop enable mid-pulse.
      switch_clr = 1'b1; enable = 1'b0; tick(1); switch_clr = 1'b0;
      tgt_p3 = 4'd9; enable = 1'b1;
      wait_for(4, 12000, t);
      chk("drain_in_pulse", pill_pulse, 1);
      enable = 1'b0; tick(1);
      chk("en_drop_hi", pill_pulse, 1);
      tick(1); chk("en_drop_lo", pill_pulse, 0);
      n0 = npulse; tick(400); chk("idle_after_drop", npulse - n0, 0);

      // Empty hopper, target 005.
      tgt_p3 = 4'd0; tgt_p2 = 4'd0; tgt_p1 = 4'd5;
      n0 = npulse; enable = 1'b1;
      wait_for(3, 1000, t); tick(300);
      chk("stall_pulses", npulse - n0, 2);
      chk("stall_empty", hopper_empty, 1);
      simu_hopper_add = 1'b1; tick(1); simu_hopper_add = 1'b0;
      chk("refill_level", hopper_level, 10);
      wait_for(1, 2000, t);
      chk("bottle_pulses", npulse - n0, 5);
      chk("level_7", hopper_level, 7);
      tick(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
